cfg_reg_bank: RTL and testbench
===============================

Name: cfg_reg_bank

Overview:
Parametrised bank of NUM_REGS configuration/status registers, each decoded at BASE_ADDR + i*ADDR_STRIDE. It generalises the single write-only config register with:
- per-register access modes;
- byte-lane write strobes;
- read-back;
- a valid/ready response channel that reports errors.

It sits between the cfg bus master and datapath blocks, and exposes all register values as one flat vector.

Parameters:
- NUM_REGS, 8, number of registers (1..64).
- ADDR_WIDTH, 32, cfg address width.
- DATA_WIDTH, 32, register width; must be a multiple of 8.
- BASE_ADDR, 32'h0, address of register 0.
- ADDR_STRIDE, 4, byte distance between registers; must be a power of two.
- RST_VALUES, {NUM_REGS*DATA_WIDTH{1'b0}}, flattened reset values; slot i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- REG_MODES, {NUM_REGS*2{1'b0}}, 2 bits per register: 0=RW, 1=RO, 2=W1C, 3=WPULSE.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- cfg_vld  in  1  request valid.
- cfg_rdy  out  1  request ready.
- cfg_wr  in  1  1=write, 0=read.
- cfg_addr  in  ADDR_WIDTH  byte address.
- cfg_data  in  DATA_WIDTH  write data.
- cfg_strb  in  DATA_WIDTH/8  byte enables (writes only).
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  decode or access error.
- hw_in  in  NUM_REGS*DATA_WIDTH  hardware value (RO) or set bits (W1C); ignored for other modes.
- reg_data  out  NUM_REGS*DATA_WIDTH  current register values.
- wr_pulse  out  NUM_REGS  one-cycle pulse per successful write.

Behaviour:
- Reset rstn, asynchronous, active-low; clock clk.
- Reset values:
  - RW/RO/W1C slots load their RST_VALUES slice; WPULSE slots load 0.
  - rsp_vld=0, rsp_data=0, rsp_err=0, wr_pulse=0.
  - Any pending response is discarded.
- Handshake:
  - cfg_rdy = !rsp_vld || rsp_rdy (combinational). One request in flight.
  - Accept = cfg_vld && cfg_rdy.
  - rsp_vld rises the cycle after accept. rsp_vld/rsp_data/rsp_err hold stable until rsp_rdy.
  - Back-to-back accepts are allowed when rsp_rdy is held high: 1 request per cycle.
- Decode:
  - hit = addr >= BASE_ADDR, (addr-BASE_ADDR) % ADDR_STRIDE == 0, and idx = (addr-BASE_ADDR)/ADDR_STRIDE < NUM_REGS.
  - Miss -> rsp_err=1, rsp_data=0, no state change, no wr_pulse.
- Read: rsp_data = register value at the accept edge (the pre-write value). A WPULSE register reads 0. Any hit read has rsp_err=0.
- Write to a hit, applied at the accept edge and visible on reg_data the next cycle:
  - RW: byte k replaced where cfg_strb[k]=1.
  - RO: no change, rsp_err=1, no wr_pulse.
  - W1C: bit cleared where cfg_data bit=1 and its byte is enabled.
  - WPULSE: enabled bytes load cfg_data for exactly one cycle, then the register returns to 0.
  - cfg_strb=0 on a non-RO write: register unchanged, rsp_err=0, wr_pulse still asserted.
- wr_pulse[idx]=1 for the single cycle after an accepted non-error write.
- RO slot: reg_data = hw_in slice registered every cycle; 1-cycle latency.
- W1C slot: every cycle reg |= hw_in slice. A simultaneous hw set and SW clear of the same bit -> the set wins, bit = 1.
- Non-power-of-two NUM_REGS: the unused index space decodes as a miss.

Decomposition:
- Package cfg_reg_pkg holds:
  - mode localparams MODE_RW/RO/W1C/WPULSE (2 bits);
  - function clog2 for index width.
- Sub-module cfg_reg_slot: one register with mode, strobe, set/clear logic and wr_pulse. It is generated NUM_REGS times.
- The top level holds decode, the response register and the handshake.

Test Plan:
- Reset with RST_VALUES slot0=32'hDEAD_BEEF -> reg_data slot0=32'hDEADBEEF, rsp_vld=0. Read addr 0x0 -> rsp_data=32'hDEADBEEF, rsp_err=0 one cycle later.
- RW slot1 holds 0x11223344; write 0xAABBCCDD to addr 0x4 with strb=4'b0101 -> reg=0x11BB33DD. Next cycle wr_pulse[1]=1 for one cycle.
- W1C slot2 holds 0xF0; hw_in sets bit0; SW writes 0x81 in the same cycle -> reg=0x71 (bit0 set wins, bit7 cleared).
- Write to RO slot3, and read addr 0x40 (idx 16 >= 8) -> rsp_err=1 for both, rsp_data=0, no reg_data change.
- rsp_rdy=0 for 3 cycles after a read -> cfg_rdy=0 and the response is held stable. With rsp_rdy=1 continuous, 4 back-to-back reads give 4 responses on consecutive cycles.
- WPULSE slot4: write 0x5 -> reg_data slot4=0x5 for exactly one cycle, then 0; read returns 0. Asserting rstn=0 while rsp_vld=1 -> rsp_vld=0 immediately.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared definitions for the configuration register bank:
// per-register access modes and an elaboration-time log2 helper.
package cfg_reg_pkg;

    localparam logic [1:0] MODE_RW     = 2'd0;
    localparam logic [1:0] MODE_RO     = 2'd1;
    localparam logic [1:0] MODE_W1C    = 2'd2;
    localparam logic [1:0] MODE_WPULSE = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cfg_reg_slot.sv
// One configuration register: access mode, byte strobes,
// hardware set/sample and the write pulse.
module cfg_reg_slot
    import cfg_reg_pkg::*;
#(
    parameter int              DATA_WIDTH = 32,
    parameter logic [1:0]      MODE       = MODE_RW,
    parameter logic [DATA_WIDTH-1:0] RST_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [DATA_WIDTH-1:0] hw_in,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  wr_pulse
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] RST_Q =
        (MODE == MODE_WPULSE) ? '0 : RST_VALUE;

    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] q_nxt;
    logic                  pulse_nxt;

    always_comb begin
        mask = '0;
        for (int k = 0; k < NB; k++) begin
            mask[k*8 +: 8] = {8{wr_strb[k]}};
        end
    end

    // Hardware set is OR-ed in after the software clear so a set wins.
    always_comb begin
        q_nxt     = q;
        pulse_nxt = 1'b0;
        case (MODE)
            MODE_RW: begin
                if (wr_en) q_nxt = (q & ~mask) | (wr_data & mask);
                pulse_nxt = wr_en;
            end
            MODE_RO: begin
                q_nxt = hw_in;
            end
            MODE_W1C: begin
                q_nxt     = (q & ~(wr_en ? (wr_data & mask) : '0)) | hw_in;
                pulse_nxt = wr_en;
            end
            MODE_WPULSE: begin
                q_nxt     = wr_en ? (wr_data & mask) : '0;
                pulse_nxt = wr_en;
            end
            default: begin
                q_nxt = q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q        <= RST_Q;
            wr_pulse <= 1'b0;
        end else begin
            q        <= q_nxt;
            wr_pulse <= pulse_nxt;
        end
    end

endmodule

// File: rtl/cfg_reg_bank.sv
// Parametrised configuration/status register bank with address
// decode, read-back and a single-entry valid/ready response channel.
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int ADDR_STRIDE = 4,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VALUES = '0,
    parameter logic [NUM_REGS*2-1:0]          REG_MODES  = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_vld,
    output logic                           cfg_rdy,
    input  logic                           cfg_wr,
    input  logic [ADDR_WIDTH-1:0]          cfg_addr,
    input  logic [DATA_WIDTH-1:0]          cfg_data,
    input  logic [DATA_WIDTH/8-1:0]        cfg_strb,
    output logic                           rsp_vld,
    input  logic                           rsp_rdy,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int SW = clog2(ADDR_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_M = ADDR_WIDTH'(ADDR_STRIDE - 1);
    localparam logic [ADDR_WIDTH-1:0] NREG_A   = ADDR_WIDTH'(NUM_REGS);

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx_a;
    logic                  hit;
    logic                  acc;
    logic                  ro_hit;
    logic                  err_nxt;
    logic [NUM_REGS-1:0]   sel;
    logic [NUM_REGS-1:0]   wr_en;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] data_nxt;

    assign off   = cfg_addr - BASE_ADDR;
    assign idx_a = off >> SW;
    assign hit   = (cfg_addr >= BASE_ADDR) &&
                   ((off & STRIDE_M) == '0) &&
                   (idx_a < NREG_A);

    assign cfg_rdy = !rsp_vld || rsp_rdy;
    assign acc     = cfg_vld && cfg_rdy;

    // Pulse registers read as zero whatever they currently drive.
    always_comb begin
        sel    = '0;
        rd_val = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = hit && (idx_a == ADDR_WIDTH'(i));
            if (sel[i] && REG_MODES[2*i +: 2] != MODE_WPULSE)
                rd_val = rd_val | reg_data[i*DATA_WIDTH +: DATA_WIDTH];
            if (sel[i] && REG_MODES[2*i +: 2] == MODE_RO)
                ro_hit = 1'b1;
        end
    end

    assign wr_en    = {NUM_REGS{acc && cfg_wr}} & sel;
    assign err_nxt  = !hit || (cfg_wr && ro_hit);
    assign data_nxt = (hit && !cfg_wr) ? rd_val : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (acc) begin
            rsp_vld  <= 1'b1;
            rsp_data <= data_nxt;
            rsp_err  <= err_nxt;
        end else if (rsp_rdy) begin
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        cfg_reg_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (REG_MODES[2*i +: 2]),
            .RST_VALUE  (RST_VALUES[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_slot (
            .clk      (clk),
            .rstn     (rstn),
            .wr_en    (wr_en[i]),
            .wr_data  (cfg_data),
            .wr_strb  (cfg_strb),
            .hw_in    (hw_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .q        (reg_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .wr_pulse (wr_pulse[i])
        );
    end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Scoreboard bench for cfg_reg_bank: directed scenarios then random
// traffic, checked against a register-level behavioural model.
module tb_cfg_reg_bank;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam logic [NR*DW-1:0] RSTV = {
        32'h7777_0000, 32'h0000_0F0F, 32'h5555_AAAA, 32'h0000_0000,
        32'h0000_0033, 32'h0000_00F0, 32'h1122_3344, 32'hDEAD_BEEF};
    localparam logic [NR*2-1:0] MODES = {
        2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0};

    // 0=RW 1=RO 2=W1C 3=WPULSE, indexed by slot
    int unsigned mode_of[NR] = '{0, 0, 2, 1, 3, 0, 2, 1};
    logic [31:0] rst_of[NR] = '{32'hDEAD_BEEF, 32'h1122_3344, 32'h0000_00F0,
                                32'h0000_0033, 32'h0, 32'h5555_AAAA,
                                32'h0000_0F0F, 32'h7777_0000};

    logic            clk = 1'b0;
    logic            rstn;
    logic            cfg_vld;
    logic            cfg_rdy;
    logic            cfg_wr;
    logic [31:0]     cfg_addr;
    logic [31:0]     cfg_data;
    logic [3:0]      cfg_strb;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic [NR*DW-1:0] hw_in;
    logic [NR*DW-1:0] reg_data;
    logic [NR-1:0]   wr_pulse;

    cfg_reg_bank #(
        .NUM_REGS    (NR),
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (DW),
        .BASE_ADDR   (32'h0),
        .ADDR_STRIDE (4),
        .RST_VALUES  (RSTV),
        .REG_MODES   (MODES)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_vld  (cfg_vld),
        .cfg_rdy  (cfg_rdy),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_strb (cfg_strb),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .hw_in    (hw_in),
        .reg_data (reg_data),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slot(input logic [NR*DW-1:0] v,
                                         input int i);
        return v[i*DW +: DW];
    endfunction

    // Reference model: state as it will be after the coming edge.
    logic [31:0] mreg[NR];
    logic [NR-1:0] mpulse;
    logic        mpend;

    always @(negedge clk) begin
        logic [31:0]  nxt[NR];
        logic [NR-1:0] npulse;
        logic [255:0] packed_m;
        logic [31:0]  bm, hw;
        longint       a, o;
        int           idx;
        bit           acc, hit;
        #1;
        if (!rstn) begin
            for (int i = 0; i < NR; i++)
                mreg[i] = (mode_of[i] == 3) ? 32'h0 : rst_of[i];
            mpulse = '0;
            mpend  = 1'b0;
        end else begin
            packed_m = '0;
            for (int i = 0; i < NR; i++) packed_m[i*DW +: DW] = mreg[i];
            chk("reg_data", reg_data, packed_m);
            chk("wr_pulse", 256'(wr_pulse), 256'(mpulse));
            acc = cfg_vld && (!mpend || rsp_rdy);
            a   = longint'(cfg_addr);
            o   = a - 0;
            hit = (a >= 0) && (o % 4 == 0) && (o / 4 < NR);
            idx = hit ? int'(o / 4) : 0;
            bm  = '0;
            for (int k = 0; k < 4; k++)
                if (cfg_strb[k]) bm[k*8 +: 8] = 8'hFF;
            npulse = '0;
            for (int i = 0; i < NR; i++) begin
                hw = slot(hw_in, i);
                case (mode_of[i])
                    1: nxt[i] = hw;
                    2: nxt[i] = mreg[i] | hw;
                    3: nxt[i] = 32'h0;
                    default: nxt[i] = mreg[i];
                endcase
            end
            if (acc) begin
                if (!hit) begin
                    exp_q.push_back('{data: 32'h0, err: 1'b1});
                end else if (!cfg_wr) begin
                    exp_q.push_back('{data: (mode_of[idx] == 3) ? 32'h0
                                            : mreg[idx], err: 1'b0});
                end else if (mode_of[idx] == 1) begin
                    exp_q.push_back('{data: 32'h0, err: 1'b1});
                end else begin
                    exp_q.push_back('{data: 32'h0, err: 1'b0});
                    npulse[idx] = 1'b1;
                    hw = slot(hw_in, idx);
                    case (mode_of[idx])
                        0: nxt[idx] = (mreg[idx] & ~bm) | (cfg_data & bm);
                        2: nxt[idx] = (mreg[idx] & ~(cfg_data & bm)) | hw;
                        default: nxt[idx] = cfg_data & bm;
                    endcase
                end
            end
            mpend  = acc || (mpend && !rsp_rdy);
            mreg   = nxt;
            mpulse = npulse;
        end
    end

    // Monitor: compares the presented response with the queue head.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
        end else begin
            chk("rsp_vld", 256'(rsp_vld), 256'(exp_q.size() != 0));
            chk("cfg_rdy", 256'(cfg_rdy),
                256'(exp_q.size() == 0 || rsp_rdy));
            if (rsp_vld && exp_q.size() != 0) begin
                chk("rsp_data", 256'(rsp_data), 256'(exp_q[0].data));
                chk("rsp_err", 256'(rsp_err), 256'(exp_q[0].err));
                if (rsp_rdy) void'(exp_q.pop_front());
            end
        end
    end

    task automatic hw_default();
        hw_in = '0;
        hw_in[3*DW +: DW] = 32'h0000_0033;
        hw_in[7*DW +: DW] = 32'h7777_0000;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic req(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
        cfg_vld  = 1'b1;
        cfg_wr   = wr;
        cfg_addr = addr;
        cfg_data = data;
        cfg_strb = strb;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cfg_rdy) begin
                @(posedge clk);
                #1;
                cfg_vld = 1'b0;
                return;
            end
        end
        chk("req_timeout", 256'(0), 256'(1));
        cfg_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit took;
        int r;
        rstn     = 1'b0;
        cfg_vld  = 1'b0;
        cfg_wr   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_strb = '0;
        rsp_rdy  = 1'b1;
        hw_default();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slot0", 256'(slot(reg_data, 0)), 256'(32'hDEAD_BEEF));
        chk("rst_rsp_vld", 256'(rsp_vld), 256'(0));
        chk("rst_wr_pulse", 256'(wr_pulse), 256'(0));
        rstn = 1'b1;
        idle(1);

        req(1'b0, 32'h0, 32'h0, 4'h0);
        req(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101);
        chk("rw_strb", 256'(slot(reg_data, 1)), 256'(32'h11BB_33DD));
        chk("rw_pulse", 256'(wr_pulse), 256'(8'h02));
        idle(1);
        chk("rw_pulse_end", 256'(wr_pulse), 256'(8'h00));

        hw_in[2*DW +: DW] = 32'h1;
        req(1'b1, 32'h8, 32'h81, 4'hF);
        hw_in[2*DW +: DW] = 32'h0;
        chk("w1c_set_wins", 256'(slot(reg_data, 2)), 256'(32'h71));

        req(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF);
        chk("ro_unchanged", 256'(slot(reg_data, 3)), 256'(32'h33));
        chk("ro_no_pulse", 256'(wr_pulse), 256'(8'h00));
        req(1'b0, 32'h40, 32'h0, 4'h0);
        req(1'b1, 32'h6, 32'h1234, 4'hF);
        req(1'b1, 32'h14, 32'h9999_9999, 4'h0);
        chk("strb0_unchanged", 256'(slot(reg_data, 5)), 256'(32'h5555_AAAA));
        chk("strb0_pulse", 256'(wr_pulse), 256'(8'h20));
        idle(1);

        rsp_rdy = 1'b0;
        req(1'b0, 32'h14, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_cfg_rdy", 256'(cfg_rdy), 256'(0));
            chk("stall_rsp_vld", 256'(rsp_vld), 256'(1));
        end
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        idle(1);

        req(1'b0, 32'h0, 32'h0, 4'h0);
        req(1'b0, 32'h4, 32'h0, 4'h0);
        req(1'b0, 32'h8, 32'h0, 4'h0);
        req(1'b0, 32'h18, 32'h0, 4'h0);
        idle(1);

        req(1'b1, 32'h10, 32'h5, 4'hF);
        chk("wpulse_high", 256'(slot(reg_data, 4)), 256'(32'h5));
        chk("wpulse_pulse", 256'(wr_pulse), 256'(8'h10));
        idle(1);
        chk("wpulse_low", 256'(slot(reg_data, 4)), 256'(32'h0));
        req(1'b0, 32'h10, 32'h0, 4'h0);
        idle(1);

        rsp_rdy = 1'b0;
        req(1'b0, 32'h4, 32'h0, 4'h0);
        #2;
        chk("pre_rst_vld", 256'(rsp_vld), 256'(1));
        rstn = 1'b0;
        #1;
        chk("async_rst_vld", 256'(rsp_vld), 256'(0));
        chk("async_rst_slot1", 256'(slot(reg_data, 1)), 256'(32'h1122_3344));
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        rsp_rdy = 1'b1;
        idle(1);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            took = cfg_vld && cfg_rdy;
            @(posedge clk);
            #1;
            if (took || !cfg_vld) begin
                cfg_vld  = ($urandom_range(0, 3) != 0);
                cfg_wr   = 1'($urandom_range(0, 1));
                r        = $urandom_range(0, 9);
                if (r < 7)
                    cfg_addr = 32'($urandom_range(0, 7) * 4);
                else if (r == 7)
                    cfg_addr = 32'($urandom_range(0, 7) * 4 +
                                   $urandom_range(1, 3));
                else if (r == 8)
                    cfg_addr = 32'(32 + $urandom_range(0, 15) * 4);
                else
                    cfg_addr = $urandom;
                cfg_data = $urandom;
                cfg_strb = 4'($urandom_range(0, 15));
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (mode_of[i] == 2)
                    hw_in[i*DW +: DW] = $urandom & $urandom & $urandom;
                else
                    hw_in[i*DW +: DW] = $urandom;
            end
        end

        cfg_vld = 1'b0;
        rsp_rdy = 1'b1;
        idle(4);
        chk("drain_empty", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
